line_burst_adaptor: RTL and testbench

LINE_BURST_ADAPTOR -- requirements
Module: line_burst_adaptor

---
 rtl/line_burst_adaptor.sv | 157 +++++++++++++++
 tb/tb_line_burst_adaptor.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/line_burst_adaptor.sv
// Cache-line to memory-burst adaptor: one LINE_W line moves as BEATS beats of BURST_W.
// Optional build macro LINE_ADAPTOR_POSTED_WRITE_EN acknowledges writes in the first WRITE cycle.
module line_burst_adaptor #(
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        line_address,
  input  logic               line_read,
  input  logic               line_write,
  input  logic [LINE_W-1:0]  line_wdata,
  output logic [LINE_W-1:0]  line_rdata,
  output logic               line_resp,
  output logic [31:0]        mem_address,
  output logic               mem_read,
  output logic               mem_write,
  output logic [BURST_W-1:0] burst_o,
  input  logic [BURST_W-1:0] burst_i,
  input  logic               mem_resp_i
);

  localparam int BEATS = LINE_W / BURST_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

`ifdef LINE_ADAPTOR_POSTED_WRITE_EN
  localparam logic POSTED_WR = 1'b1;
`else
  localparam logic POSTED_WR = 1'b0;
`endif

  logic [1:0]         state_q,     state_d;
  logic [CNT_W-1:0]   cnt_q,       cnt_d;
  logic [31:0]        addr_q,      addr_d;
  logic [LINE_W-1:0]  wdata_q,     wdata_d;
  logic [LINE_W-1:0]  rdata_q,     rdata_d;
  logic               resp_q,      resp_d;
  logic               mem_read_q,  mem_read_d;
  logic               mem_write_q, mem_write_d;
  logic [BURST_W-1:0] burst_q,     burst_d;

  // Lines are 32-byte aligned, so the offset bits never reach memory.
  logic addr_unused_s;
  assign addr_unused_s = ^line_address[4:0];

  // Sequencing: accept a request in IDLE, move one beat per strobe, retire in DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    resp_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (line_write) begin
          state_d = ST_WRITE;
          addr_d  = {line_address[31:5], 5'b00000};
          wdata_d = line_wdata;
          cnt_d   = '0;
          resp_d  = POSTED_WR;
        end else if (line_read) begin
          state_d = ST_READ;
          addr_d  = {line_address[31:5], 5'b00000};
          wdata_d = line_wdata;
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        if (mem_resp_i) begin
          rdata_d[int'(cnt_q)*BURST_W +: BURST_W] = burst_i;
          if (cnt_q == LAST_BEAT) begin
            state_d = ST_DONE;
            resp_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          state_d = ST_READ;
        end
      end
      ST_WRITE: begin
        if (mem_resp_i) begin
          if (cnt_q == LAST_BEAT) begin
            state_d = ST_DONE;
            resp_d  = ~POSTED_WR;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          state_d = ST_WRITE;
        end
      end
      ST_DONE: begin
        // Requests still held here are ignored; IDLE re-samples them next cycle.
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Registered memory-side strobes and the write beat, derived from the next state.
  always_comb begin
    mem_read_d  = (state_d == ST_READ);
    mem_write_d = (state_d == ST_WRITE);
    if (state_d == ST_WRITE) begin
      burst_d = wdata_d[int'(cnt_d)*BURST_W +: BURST_W];
    end else begin
      burst_d = '0;
    end
  end

  // State and output registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      addr_q      <= 32'h0000_0000;
      wdata_q     <= '0;
      rdata_q     <= '0;
      resp_q      <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      burst_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      resp_q      <= resp_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      burst_q     <= burst_d;
    end
  end

  assign line_rdata  = rdata_q;
  assign line_resp   = resp_q;
  assign mem_address = addr_q;
  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign burst_o     = burst_q;

endmodule

// File: tb/tb_line_burst_adaptor.sv
// Directed plus randomized bench for line_burst_adaptor; expectations come from a line-level model.
module tb_line_burst_adaptor;

  localparam int LINE_W  = 256;
  localparam int BURST_W = 64;
  localparam int BEATS   = LINE_W / BURST_W;

`ifdef LINE_ADAPTOR_POSTED_WRITE_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  logic               clk;
  logic               rst;
  logic [31:0]        line_address;
  logic               line_read;
  logic               line_write;
  logic [LINE_W-1:0]  line_wdata;
  logic [LINE_W-1:0]  line_rdata;
  logic               line_resp;
  logic [31:0]        mem_address;
  logic               mem_read;
  logic               mem_write;
  logic [BURST_W-1:0] burst_o;
  logic [BURST_W-1:0] burst_i;
  logic               mem_resp_i;

  int n_assert = 0;
  int n_fail   = 0;
  logic [LINE_W-1:0] exp_rdata;

  line_burst_adaptor #(.LINE_W(LINE_W), .BURST_W(BURST_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .line_address (line_address),
    .line_read    (line_read),
    .line_write   (line_write),
    .line_wdata   (line_wdata),
    .line_rdata   (line_rdata),
    .line_resp    (line_resp),
    .mem_address  (mem_address),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .burst_o      (burst_o),
    .burst_i      (burst_i),
    .mem_resp_i   (mem_resp_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [BURST_W-1:0] rnd_beat();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [LINE_W-1:0] rnd_line();
    logic [LINE_W-1:0] v;
    for (int i = 0; i < LINE_W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Read one line. hold keeps line_read high through completion; directed uses 0x11..,0x22.. beats.
  task automatic read_txn(input logic [31:0] addr, input int glo, input int ghi,
                          input bit hold, input bit directed);
    logic [LINE_W-1:0]  line;
    logic [BURST_W-1:0] beat;
    int g;
    line = '0;
    line_address = addr; line_read = 1'b1; line_write = 1'b0; mem_resp_i = 1'b0;
    @(negedge clk);
    chk("rd_accept_mem_read", LINE_W'(mem_read), LINE_W'(1'b1));
    chk("rd_accept_mem_write", LINE_W'(mem_write), LINE_W'(1'b0));
    chk("rd_addr", LINE_W'(mem_address), LINE_W'(addr & 32'hFFFF_FFE0));
    chk("rd_no_early_resp", LINE_W'(line_resp), LINE_W'(1'b0));
    line_read = hold; line_address = $urandom; line_wdata = rnd_line();
    for (int b = 0; b < BEATS; b++) begin
      g = int'($urandom_range(ghi, glo));
      for (int j = 0; j < g; j++) begin
        mem_resp_i = 1'b0; burst_i = rnd_beat();
        @(negedge clk);
        chk("rd_gap_mem_read", LINE_W'(mem_read), LINE_W'(1'b1));
        chk("rd_gap_resp", LINE_W'(line_resp), LINE_W'(1'b0));
      end
      beat = directed ? 64'h1111_1111_1111_1111 * 64'(b + 1) : rnd_beat();
      line[b*BURST_W +: BURST_W] = beat;
      mem_resp_i = 1'b1; burst_i = beat;
      @(negedge clk);
      if (b < BEATS - 1) begin
        chk("rd_beat_mem_read", LINE_W'(mem_read), LINE_W'(1'b1));
        chk("rd_beat_resp", LINE_W'(line_resp), LINE_W'(1'b0));
      end else begin
        exp_rdata = line;
        chk("rd_done_resp", LINE_W'(line_resp), LINE_W'(1'b1));
        chk("rd_done_mem_read", LINE_W'(mem_read), LINE_W'(1'b0));
        chk("rd_done_mem_write", LINE_W'(mem_write), LINE_W'(1'b0));
        chk("rd_done_rdata", line_rdata, exp_rdata);
      end
    end
    line_read = hold; mem_resp_i = 1'($urandom); burst_i = rnd_beat();
    @(negedge clk);
    chk("rd_after_resp", LINE_W'(line_resp), LINE_W'(1'b0));
    chk("rd_after_mem_read", LINE_W'(mem_read), LINE_W'(1'b0));
    chk("rd_after_rdata", line_rdata, exp_rdata);
    mem_resp_i = 1'b0;
  endtask

  // Write one line; both raises line_read alongside, and stray line_read toggles during the burst.
  task automatic write_txn(input logic [31:0] addr, input logic [LINE_W-1:0] data,
                           input int glo, input int ghi, input bit both);
    int g;
    line_address = addr; line_write = 1'b1; line_read = both; line_wdata = data; mem_resp_i = 1'b0;
    @(negedge clk);
    chk("wr_accept_mem_write", LINE_W'(mem_write), LINE_W'(1'b1));
    chk("wr_accept_mem_read", LINE_W'(mem_read), LINE_W'(1'b0));
    chk("wr_addr", LINE_W'(mem_address), LINE_W'(addr & 32'hFFFF_FFE0));
    chk("wr_first_resp", LINE_W'(line_resp), LINE_W'(POSTED));
    chk("wr_beat0", LINE_W'(burst_o), LINE_W'(data[0 +: BURST_W]));
    line_write = 1'b0; line_wdata = rnd_line(); line_address = $urandom;
    for (int b = 0; b < BEATS; b++) begin
      g = int'($urandom_range(ghi, glo));
      for (int j = 0; j < g; j++) begin
        mem_resp_i = 1'b0; line_read = 1'($urandom);
        @(negedge clk);
        chk("wr_gap_mem_write", LINE_W'(mem_write), LINE_W'(1'b1));
        chk("wr_gap_mem_read", LINE_W'(mem_read), LINE_W'(1'b0));
        chk("wr_gap_hold_beat", LINE_W'(burst_o), LINE_W'(data[b*BURST_W +: BURST_W]));
        chk("wr_gap_resp", LINE_W'(line_resp), LINE_W'(1'b0));
      end
      mem_resp_i = 1'b1; line_read = 1'($urandom);
      @(negedge clk);
      chk("wr_mem_read_low", LINE_W'(mem_read), LINE_W'(1'b0));
      if (b < BEATS - 1) begin
        chk("wr_beat_mem_write", LINE_W'(mem_write), LINE_W'(1'b1));
        chk("wr_next_beat", LINE_W'(burst_o), LINE_W'(data[(b+1)*BURST_W +: BURST_W]));
        chk("wr_beat_resp", LINE_W'(line_resp), LINE_W'(1'b0));
      end else begin
        chk("wr_done_mem_write", LINE_W'(mem_write), LINE_W'(1'b0));
        chk("wr_done_resp", LINE_W'(line_resp), LINE_W'(!POSTED));
      end
    end
    line_read = 1'b0; mem_resp_i = 1'($urandom);
    @(negedge clk);
    chk("wr_after_resp", LINE_W'(line_resp), LINE_W'(1'b0));
    chk("wr_after_mem_write", LINE_W'(mem_write), LINE_W'(1'b0));
    chk("wr_after_mem_read", LINE_W'(mem_read), LINE_W'(1'b0));
    chk("wr_rdata_untouched", line_rdata, exp_rdata);
    mem_resp_i = 1'b0;
  endtask

  // Idle cycles with stray beat strobes that must have no effect.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      line_read = 1'b0; line_write = 1'b0; mem_resp_i = 1'($urandom); burst_i = rnd_beat();
      @(negedge clk);
      chk("idle_mem_read", LINE_W'(mem_read), LINE_W'(1'b0));
      chk("idle_mem_write", LINE_W'(mem_write), LINE_W'(1'b0));
      chk("idle_resp", LINE_W'(line_resp), LINE_W'(1'b0));
      chk("idle_rdata", line_rdata, exp_rdata);
    end
    mem_resp_i = 1'b0;
  endtask

  initial begin
    logic [LINE_W-1:0] wline;
    rst = 1'b0; line_address = 32'h0000_0000; line_read = 1'b0; line_write = 1'b0;
    line_wdata = '0; burst_i = '0; mem_resp_i = 1'b0;
    exp_rdata = '0;
    repeat (2) @(negedge clk);
    chk("reset_line_resp", LINE_W'(line_resp), LINE_W'(1'b0));
    chk("reset_mem_read", LINE_W'(mem_read), LINE_W'(1'b0));
    chk("reset_mem_write", LINE_W'(mem_write), LINE_W'(1'b0));
    chk("reset_burst_o", LINE_W'(burst_o), LINE_W'(0));
    chk("reset_mem_address", LINE_W'(mem_address), LINE_W'(0));
    chk("reset_line_rdata", line_rdata, exp_rdata);
    rst = 1'b1;

    // Directed read with back-to-back beats.
    read_txn(32'h0000_1234, 0, 0, 1'b0, 1'b1);
    chk("directed_rd_line", line_rdata,
        256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111);
    chk("directed_rd_addr", LINE_W'(mem_address), LINE_W'(32'h0000_1220));
    idle(2);

    // Directed write, two idle cycles before every beat.
    wline = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
             64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
    write_txn(32'h0000_4567, wline, 2, 2, 1'b0);
    idle(1);

    // Read and write requested together: write must win.
    write_txn($urandom, rnd_line(), 0, 1, 1'b1);
    idle(1);

    // Held read: one pulse, then re-accepted the cycle after DONE.
    read_txn($urandom, 0, 2, 1'b1, 1'b0);
    read_txn($urandom, 0, 2, 1'b0, 1'b0);
    idle(1);

    // Reset after two beats of a read.
    line_address = $urandom; line_read = 1'b1;
    @(negedge clk);
    line_read = 1'b0;
    for (int b = 0; b < 2; b++) begin
      mem_resp_i = 1'b1; burst_i = rnd_beat();
      @(negedge clk);
    end
    mem_resp_i = 1'b0;
    #2 rst = 1'b0;
    #1;
    exp_rdata = '0;
    chk("midrst_line_resp", LINE_W'(line_resp), LINE_W'(1'b0));
    chk("midrst_mem_read", LINE_W'(mem_read), LINE_W'(1'b0));
    chk("midrst_mem_write", LINE_W'(mem_write), LINE_W'(1'b0));
    chk("midrst_burst_o", LINE_W'(burst_o), LINE_W'(0));
    chk("midrst_mem_address", LINE_W'(mem_address), LINE_W'(0));
    chk("midrst_line_rdata", line_rdata, exp_rdata);
    for (int i = 0; i < 2; i++) begin
      mem_resp_i = 1'b1;
      @(negedge clk);
      chk("in_rst_resp", LINE_W'(line_resp), LINE_W'(1'b0));
      chk("in_rst_mem_read", LINE_W'(mem_read), LINE_W'(1'b0));
    end
    mem_resp_i = 1'b0;
    rst = 1'b1;
    read_txn($urandom, 0, 1, 1'b0, 1'b0);

    // Randomized mix of transactions.
    for (int t = 0; t < 24; t++) begin
      case ($urandom_range(2, 0))
        0: read_txn($urandom, 0, 3, 1'($urandom_range(3, 0) == 0), 1'b0);
        1: write_txn($urandom, rnd_line(), 0, 3, 1'b0);
        default: write_txn($urandom, rnd_line(), 0, 2, 1'b1);
      endcase
      idle(int'($urandom_range(2, 0)));
    end
    idle(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
